// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster timing bundle produced by vga_timing_gen. The drawers and the pin
//   driver consume it.
//   master : driven by the timing generator
//   slave  : consumed by drawers / output stage
//   Signals:
//     DrawX, DrawY   current raster position
//     hs, vs, blank  syncs (active low) and display enable, aligned to DrawX/Y
//     hs_d, vs_d, blank_d  the same, delayed to line up with drawer colour
//     frame_start    one-cycle strobe at (0,0)
//     frame_count    frame index, wraps modulo 256
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       hs_d;
  logic       vs_d;
  logic       blank_d;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, blank, hs_d, vs_d, blank_d,
           frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank, hs_d, vs_d, blank_d,
          frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 Hz raster timing: position counters, active-low syncs, display
//   enable, copies of the syncs/enable delayed by PIPE_DELAY cycles to match
//   the drawers' colour latency, and frame-boundary strobe/count.
//   Ports:
//     vga_clk  pixel clock (sole clock)
//     reset    synchronous, active-high
//     bus      vga_timing_gen_if.master, all outputs registered
//              (the *_d outputs equal the undelayed ones when PIPE_DELAY=0)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic                vga_clk,
  input  logic                reset,
  vga_timing_gen_if.master    bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Elaboration-time guards: counters are 10 bits wide.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: horizontal total exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: vertical total exceeds 1024");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..7");
  end

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  logic [9:0] x_q, y_q;
  logic [9:0] x_nxt, y_nxt;
  logic       x_wrap;
  logic       hs_q, vs_q, blank_q;
  logic       frame_start_q;
  logic [7:0] frame_count_q;
  logic       at_origin_nxt;
  sync_t      sync_q, sync_d;

  // Next raster position. The syncs are decoded from these values and then
  // registered, so they line up with the position shown in the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    x_nxt  = x_q + 10'd1;
    y_nxt  = y_q;
    x_wrap = (x_q == H_LAST);
    if (x_wrap) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  assign at_origin_nxt = (x_nxt == '0) && (y_nxt == '0);

  // The reset position is the last pixel of the frame, so the first edge out
  // of reset lands on (0,0) and raises frame_start with the count at 0.
  always_ff @(posedge vga_clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'hFF;
    end else begin
      x_q           <= x_nxt;
      y_q           <= y_nxt;
      hs_q          <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
      vs_q          <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
      blank_q       <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      frame_start_q <= at_origin_nxt;
      if (at_origin_nxt) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign sync_q = '{hs: hs_q, vs: vs_q, blank: blank_q};

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign sync_d = sync_q;
  end else begin : g_delay
    // Stage k holds the registered syncs from k+1 cycles ago.
    sync_t pipe_q [PIPE_DELAY];

    always_ff @(posedge vga_clk) begin
      if (reset) begin
        // NOTE: every stage is reset (not just the head) so the delayed
        // outputs show idle syncs immediately instead of stale history.
        for (int k = 0; k < PIPE_DELAY; k++) begin
          pipe_q[k] <= SYNC_IDLE;
        end
      end else begin
        pipe_q[0] <= sync_q;
        for (int k = 1; k < PIPE_DELAY; k++) begin
          pipe_q[k] <= pipe_q[k-1];
        end
      end
    end

    assign sync_d = pipe_q[PIPE_DELAY-1];
  end

  assign bus.DrawX       = x_q;
  assign bus.DrawY       = y_q;
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.blank       = blank_q;
  assign bus.hs_d        = sync_d.hs;
  assign bus.vs_d        = sync_d.vs;
  assign bus.blank_d     = sync_d.blank;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_count_q;

endmodule
